cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of functional-unit result channels (2..8).
REQ-002 SHALL have parameter W_DATA, default 32, meaning result data width.
REQ-003 SHALL have parameter W_TAG, default 6, meaning destination tag width.
REQ-004 SHALL have parameter DEPTH, default 2, meaning per-channel result buffer entries (power of two, 1..8).
REQ-005 SHALL have port clk, input, 1, meaning the single clock, with reset synchronous and active-high.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port fu_valid, input, N_CH, meaning a per-channel result offered.
REQ-008 SHALL have port fu_data, input, N_CH*W_DATA, meaning per-channel result data, channel i in bits [i*W_DATA +: W_DATA].
REQ-009 SHALL have port fu_tag, input, N_CH*W_TAG, meaning per-channel destination tag.
REQ-010 SHALL have port fu_branch, input, N_CH, meaning the result is a branch resolution.
REQ-011 SHALL have port fu_taken, input, N_CH, meaning the branch was taken.
REQ-012 SHALL have port fu_done, output, N_CH, meaning channel buffer not full (ready).
REQ-013 SHALL have port flush, input, 1, meaning discard all buffered results.
REQ-014 SHALL have ports cdb_data (W_DATA), cdb_tag (W_TAG), cdb_valid (1), cdb_branch (1) and cdb_branch_taken (1), all outputs, meaning the broadcast bus.
REQ-015 SHALL have port cdb_grant, output, N_CH, meaning a one-hot source of the current broadcast.

Function
REQ-016 SHALL accept a channel entry on a rising edge where fu_valid[i] && fu_done[i].
REQ-017 SHALL drive fu_done[i] combinationally as "buffer i not full"; a full buffer is not ready even when it is popped in the same cycle.
REQ-018 SHALL keep each channel buffer FIFO-ordered, with wrap-around read and write pointers and a count of 0..DEPTH.
REQ-019 SHALL, each cycle, select at most one non-empty buffer, pop its head, and register that head onto the cdb_* outputs at the next edge.
REQ-020 SHALL give a latency such that an entry accepted at edge E appears with cdb_valid=1 no earlier than after edge E+1; there is no combinational bypass.
REQ-021 SHALL use round-robin selection by default: search starts at the channel after the last granted one, and the pointer advances only on a grant.
REQ-022 SHALL drive cdb_valid=0, cdb_grant=0 and hold cdb_data/cdb_tag at their last values when all buffers are empty.
REQ-023 SHALL, on a simultaneous push and pop of the same buffer, pop the old head and append the new entry, leaving the count unchanged.
REQ-024 SHALL, when flush=1, clear all counts and pointers at that edge, drop any same-cycle push, set cdb_valid=0 after the edge, and leave the round-robin pointer unchanged.
REQ-025 SHALL assert cdb_grant one-hot exactly when cdb_valid=1.
REQ-026 SHALL never drop or duplicate an accepted entry absent flush or reset.

Reset
REQ-027 SHALL, on reset, zero every buffer count and pointer, and set cdb_valid=0, cdb_branch=0, cdb_branch_taken=0, cdb_grant=0, cdb_data=0 and cdb_tag=0.
REQ-028 SHALL set the round-robin pointer on reset so that channel 0 wins first.
REQ-029 SHALL let reset override flush and pushes, including when asserted mid-stream.
REQ-030 SHALL drive fu_done = all ones in the cycle after reset.

Configuration
REQ-031 SHALL use fixed priority (lowest index wins) in place of round-robin when macro CDB_ARB_FIXED_PRIO_EN is defined; all other behaviour is identical.
REQ-032 SHALL use round-robin per REQ-021 when CDB_ARB_FIXED_PRIO_EN is undefined.

Verification
REQ-033 SHALL cover single-result latency: push ch2 data=0xDEADBEEF tag=5 at edge 1 -> cdb_valid=1, data=0xDEADBEEF, tag=5, grant=4'b0100 after edge 2, then cdb_valid=0.
REQ-034 SHALL cover round-robin: all 4 channels push one entry the same cycle -> broadcasts on 4 consecutive cycles in order 0,1,2,3; a second burst follows 0,1,2,3.
REQ-035 SHALL cover full/backpressure with DEPTH=2: push ch1 for 3 cycles while ch0 is streaming -> fu_done[1]=0 on the third cycle, the third entry is not accepted, and it is accepted later with order preserved.
REQ-036 SHALL cover flush: 3 entries buffered, flush pulsed with a concurrent ch3 push -> no broadcast after the flush edge, and the ch3 entry is never seen.
REQ-037 SHALL cover branch fields: ch0 pushes branch=1 taken=1 tag=9 -> cdb_branch=1 and cdb_branch_taken=1 in the broadcast cycle only.
REQ-038 SHALL cover fixed priority: with CDB_ARB_FIXED_PRIO_EN defined, ch0 and ch3 both streaming continuously -> ch3 is never granted while ch0 is non-empty.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                   |
// | Purpose  : Buffers per-channel FU results and broadcasts one per cycle   |
// |            on the common data bus (round-robin, or fixed priority when   |
// |            CDB_ARB_FIXED_PRIO_EN is defined).                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int N_CH   = 4,
  parameter int W_DATA = 32,
  parameter int W_TAG  = 6,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        fu_valid,
  input  logic [N_CH*W_DATA-1:0] fu_data,
  input  logic [N_CH*W_TAG-1:0]  fu_tag,
  input  logic [N_CH-1:0]        fu_branch,
  input  logic [N_CH-1:0]        fu_taken,
  output logic [N_CH-1:0]        fu_done,
  input  logic                   flush,
  output logic [W_DATA-1:0]      cdb_data,
  output logic [W_TAG-1:0]       cdb_tag,
  output logic                   cdb_valid,
  output logic                   cdb_branch,
  output logic                   cdb_branch_taken,
  output logic [N_CH-1:0]        cdb_grant
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ENT_W = W_DATA + W_TAG + 2;

  logic [N_CH-1:0]            push;
  logic [N_CH-1:0]            nonempty;
  logic [N_CH-1:0]            grant;
  logic [N_CH-1:0][ENT_W-1:0] head;
  logic [IDX_W-1:0]           sel;
  logic                       any_raw;
  logic                       any;
  logic [ENT_W-1:0]           head_sel;

  logic [W_DATA-1:0] data_q;
  logic [W_TAG-1:0]  tag_q;
  logic              valid_q;
  logic              branch_q;
  logic              taken_q;
  logic [N_CH-1:0]   grant_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;

    // A full buffer stays not-ready even if its head is popped this cycle.
    assign fu_done[i]  = (cnt_q != CNT_W'(DEPTH));
    assign nonempty[i] = (cnt_q != '0);
    assign push[i]     = fu_valid[i] & fu_done[i] & ~flush;
    assign head[i]     = mem_q[rptr_q];

    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem_q[wptr_q] <= {fu_branch[i], fu_taken[i],
                          fu_tag[i*W_TAG +: W_TAG], fu_data[i*W_DATA +: W_DATA]};
      end
    end

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[i])  wptr_q <= ptr_inc(wptr_q);
        if (grant[i]) rptr_q <= ptr_inc(rptr_q);
        case ({push[i], grant[i]})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    any_raw = 1'b0;
    sel     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (nonempty[k]) begin
        any_raw = 1'b1;
        sel     = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] cand;

  // Search begins one past the last granted channel.
  always_comb begin
    any_raw = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % N_CH);
      if (!any_raw && nonempty[cand]) begin
        any_raw = 1'b1;
        sel     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= IDX_W'(N_CH - 1);
    end else if (any) begin
      rr_q <= sel;
    end
  end
`endif

  assign any      = any_raw & ~flush;
  assign grant    = any ? (N_CH'(1) << sel) : '0;
  assign head_sel = head[sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
      grant_q  <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      valid_q  <= any;
      grant_q  <= grant;
      branch_q <= any & head_sel[ENT_W-1];
      taken_q  <= any & head_sel[ENT_W-2];
      if (any) begin
        data_q <= head_sel[W_DATA-1:0];
        tag_q  <= head_sel[W_DATA +: W_TAG];
      end
    end
  end

  assign cdb_data         = data_q;
  assign cdb_tag          = tag_q;
  assign cdb_valid        = valid_q;
  assign cdb_branch       = branch_q;
  assign cdb_branch_taken = taken_q;
  assign cdb_grant        = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                                |
// | Purpose  : Randomized scoreboard bench for cdb_arbiter against a queue-  |
// |            based arbitration model (honours CDB_ARB_FIXED_PRIO_EN).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int WD = 32;
  localparam int WT = 6;
  localparam int D  = 2;
  localparam int BW = 1 + N + 2 + WT + WD;

  typedef struct packed {
    logic          br;
    logic          tk;
    logic [WT-1:0] tag;
    logic [WD-1:0] data;
  } ent_t;

  typedef struct {
    int   ch;
    ent_t e;
  } sb_t;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    fu_valid, fu_branch, fu_taken, fu_done, cdb_grant;
  logic [N*WD-1:0] fu_data;
  logic [N*WT-1:0] fu_tag;
  logic [WD-1:0]   cdb_data;
  logic [WT-1:0]   cdb_tag;
  logic            cdb_valid, cdb_branch, cdb_branch_taken;

  ent_t         off [N];
  logic [N-1:0] off_v = '0;
  ent_t         tx [N][$];
  ent_t         mq [N][$];
  sb_t          sb [$];
  logic [N-1:0] acc      = '0;
  logic [N-1:0] exp_done = '1;
  logic         dropped  = 1'b0;
  int           last_gnt = N - 1;
  logic [WD-1:0] last_data = '0;
  logic [WT-1:0] last_tag  = '0;
  int           checks = 0;
  int           errors = 0;
  logic         mon_en = 1'b0;

  cdb_arbiter #(.N_CH(N), .W_DATA(WD), .W_TAG(WT), .DEPTH(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .fu_valid         (fu_valid),
    .fu_data          (fu_data),
    .fu_tag           (fu_tag),
    .fu_branch        (fu_branch),
    .fu_taken         (fu_taken),
    .fu_done          (fu_done),
    .flush            (flush),
    .cdb_data         (cdb_data),
    .cdb_tag          (cdb_tag),
    .cdb_valid        (cdb_valid),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken),
    .cdb_grant        (cdb_grant)
  );

  always #5 clk = ~clk;

  always_comb begin
    fu_valid  = off_v;
    fu_data   = '0;
    fu_tag    = '0;
    fu_branch = '0;
    fu_taken  = '0;
    for (int i = 0; i < N; i++) begin
      fu_data[i*WD +: WD] = off[i].data;
      fu_tag[i*WT +: WT]  = off[i].tag;
      fu_branch[i]        = off[i].br;
      fu_taken[i]         = off[i].tk;
    end
  end

  function automatic ent_t mk(input logic br, input logic tk,
                              input logic [WT-1:0] tag, input logic [WD-1:0] data);
    ent_t e;
    e.br = br; e.tk = tk; e.tag = tag; e.data = data;
    return e;
  endfunction

  // Reference: per-channel queues, one pick per edge, pops before pushes.
  task automatic model_edge();
    int           w;
    ent_t         e;
    logic [N-1:0] rdy;
    acc     = '0;
    dropped = reset | flush;
    if (reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      sb.delete();
      last_gnt  = N - 1;
      last_data = '0;
      last_tag  = '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
      w = -1;
`ifdef CDB_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (w < 0 && mq[k].size() != 0) w = k;
`else
      for (int k = 1; k <= N; k++) if (w < 0 && mq[(last_gnt + k) % N].size() != 0) w = (last_gnt + k) % N;
`endif
      if (w >= 0) begin
        e = mq[w].pop_front();
        sb.push_back('{ch: w, e: e});
        last_data = e.data;
        last_tag  = e.tag;
        last_gnt  = w;
      end
      for (int i = 0; i < N; i++) begin
        if (off_v[i] && rdy[i]) begin
          mq[i].push_back(off[i]);
          acc[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) exp_done[i] = (mq[i].size() < D);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] || dropped) off_v[i] = 1'b0;
      if (!off_v[i] && tx[i].size() > 0) begin
        off[i]   = tx[i].pop_front();
        off_v[i] = 1'b1;
      end
    end
  endtask

  function automatic logic busy();
    logic b;
    b = (off_v != '0);
    for (int i = 0; i < N; i++) if (tx[i].size() != 0 || mq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Monitor: compares the bus against the scoreboard on every falling edge.
  sb_t           mon_s;
  logic [BW-1:0] exp_bus, act_bus;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (fu_done !== exp_done) begin
          errors++;
          $display("FAIL fu_done @%0t: got %b expected %b", $time, fu_done, exp_done);
        end
        if (sb.size() > 0) begin
          mon_s   = sb.pop_front();
          exp_bus = {1'b1, N'(1 << mon_s.ch), mon_s.e.br, mon_s.e.tk, mon_s.e.tag, mon_s.e.data};
        end else begin
          exp_bus = {1'b0, {N{1'b0}}, 2'b00, last_tag, last_data};
        end
        act_bus = {cdb_valid, cdb_grant, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data};
        checks++;
        if (act_bus !== exp_bus) begin
          errors++;
          $display("FAIL cdb_bus @%0t: got v=%b g=%b br=%b tk=%b tag=%0d data=%h expected v=%b g=%b br=%b tk=%b tag=%0d data=%h",
                   $time, act_bus[BW-1], act_bus[BW-2 -: N], act_bus[WT+WD+1], act_bus[WT+WD],
                   act_bus[WD +: WT], act_bus[WD-1:0], exp_bus[BW-1], exp_bus[BW-2 -: N],
                   exp_bus[WT+WD+1], exp_bus[WT+WD], exp_bus[WD +: WT], exp_bus[WD-1:0]);
        end
      end
    end
  end

  initial begin
    int r;
    for (int i = 0; i < N; i++) off[i] = '0;
    reset = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Single result on channel 2
    tx[2].push_back(mk(1'b0, 1'b0, 6'd5, 32'hDEADBEEF));
    repeat (5) step();

    // Two simultaneous bursts on all channels
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) tx[i].push_back(mk(1'b0, 1'b0, WT'(8*b + i), 32'h1000_0000 + 32'(16*b + i)));
    repeat (12) step();

    // Channel 1 fills while channel 0 streams
    for (int i = 0; i < 6; i++) tx[0].push_back(mk(1'b0, 1'b0, 6'd1, 32'hA000_0000 + 32'(i)));
    for (int i = 0; i < 3; i++) tx[1].push_back(mk(1'b0, 1'b0, 6'd2, 32'hB000_0000 + 32'(i)));
    repeat (16) step();

    // Flush with buffered entries and a concurrent channel 3 push
    for (int i = 0; i < 3; i++) begin
      tx[i].push_back(mk(1'b0, 1'b0, 6'd3, 32'hC000_0000 + 32'(i)));
      tx[i].push_back(mk(1'b0, 1'b0, 6'd4, 32'hC100_0000 + 32'(i)));
    end
    step();
    step();
    step();
    off[3]   = mk(1'b0, 1'b0, 6'd63, 32'hF1F1F1F1);
    off_v[3] = 1'b1;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    repeat (6) step();

    // Branch fields
    tx[0].push_back(mk(1'b1, 1'b1, 6'd9, 32'h0000_0B0B));
    repeat (5) step();

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 4 && tx[i].size() < 3) begin
          r = $urandom_range(0, 3);
          tx[i].push_back(mk(r[0], r[0] & r[1], WT'($urandom_range(0, 63)), $urandom));
        end
      end
      r     = $urandom_range(0, 199);
      flush = (r < 4);
      reset = (r == 5);
      step();
    end
    flush = 1'b0;
    reset = 1'b0;

    for (int t = 0; t < 400 && busy(); t++) step();
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain_timeout: traffic still pending after 400 cycles, expected drained");
    end
    repeat (3) step();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d expected broadcasts never seen, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
